// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state type and config legality helper for the sequence detector
package seq_det_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic len_is_legal(input int len, input int max_len);
    return len >= 1 && len <= max_len;
  endfunction
endpackage

// File: rtl/detect_programmable_sequence_using_fsm_if.sv
// detect_programmable_sequence_using_fsm_if: config strobe, qualified serial input and detector status
interface detect_programmable_sequence_using_fsm_if #(parameter int MAX_LEN = 8, parameter int CNT_W = 8);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic cfg_overlap;
  logic a_valid;
  logic a;
  logic detected;
  logic [CNT_W-1:0] match_count;
  logic armed;
  logic cfg_err;
  modport master(output cfg_load, cfg_pattern, cfg_len, cfg_overlap, a_valid, a,
                 input detected, match_count, armed, cfg_err);
  modport slave(input cfg_load, cfg_pattern, cfg_len, cfg_overlap, a_valid, a,
                output detected, match_count, armed, cfg_err);
endinterface

// File: rtl/seq_det_sat_counter.sv
// seq_det_sat_counter: width-parametrised counter with synchronous clear that sticks at all-ones
module seq_det_sat_counter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/detect_programmable_sequence_using_fsm.sv
// detect_programmable_sequence_using_fsm: run-time programmable serial pattern detector with match counter
module detect_programmable_sequence_using_fsm
  import seq_det_pkg::*;
#(parameter int MAX_LEN = 8, parameter int CNT_W = 8) (
  input logic clk,
  input logic rst,
  detect_programmable_sequence_using_fsm_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  state_t state;
  logic [MAX_LEN-1:0] pattern, hist, nxt_hist, mask;
  logic [LEN_W-1:0] len, fill, fill_nxt;
  logic [LEN_W:0] fill_inc;
  logic [CNT_W-1:0] count;
  logic overlap, accept, legal, match;
  assign legal = len_is_legal(int'(bus.cfg_len), MAX_LEN);
  assign accept = state == RUN && bus.a_valid && !bus.cfg_load;
  assign nxt_hist = {hist[MAX_LEN-2:0], bus.a};
  // fill gates the compare, so stale history beyond fill never produces a match
  assign mask = ~({MAX_LEN{1'b1}} << len);
  assign fill_inc = {1'b0, fill} + (LEN_W+1)'(1);
  assign fill_nxt = fill_inc > (LEN_W+1)'(MAX_LEN) ? LEN_W'(MAX_LEN) : fill_inc[LEN_W-1:0];
  assign match = accept && fill_inc >= {1'b0, len} && ((nxt_hist ^ pattern) & mask) == '0;
  assign bus.armed = state == RUN;
  assign bus.match_count = count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      pattern <= '0;
      len <= '0;
      overlap <= 1'b0;
      hist <= '0;
      fill <= '0;
      bus.detected <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      bus.detected <= match;
      if (bus.cfg_load) begin
        bus.cfg_err <= !legal;
        state <= legal ? RUN : IDLE;
        if (legal) begin
          pattern <= bus.cfg_pattern;
          len <= bus.cfg_len;
          overlap <= bus.cfg_overlap;
          hist <= '0;
          fill <= '0;
        end
      end else if (accept) begin
        hist <= nxt_hist;
        fill <= match && !overlap ? '0 : fill_nxt;
      end
    end
  seq_det_sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(bus.cfg_load && legal),
    .inc(match),
    .cnt(count)
  );
endmodule

// File: doc/detect_programmable_sequence_using_fsm.md
Name: detect_programmable_sequence_using_fsm

Overview:
Run-time-programmable serial bit-sequence detector; successor to the fixed 4/6-bit detectors. Pattern (up to MAX_LEN bits), its length and overlap mode are loaded through a config strobe. Serial input is qualified by a valid signal. The block pulses on every match and keeps a saturating match count. It sits on any serial bit stream that needs pattern recognition, e.g. sync-word or preamble search.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (legal range 2..32)
CNT_W, 8, width of the saturating match counter
LEN_W (localparam), $clog2(MAX_LEN+1), width of the length field

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
cfg_load  input  1  one-cycle strobe; samples cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is received first, bit [0] last
cfg_len  input  LEN_W  pattern length; legal 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after each match
a_valid  input  1  qualifies a; bits are accepted only when 1
a  input  1  serial data bit
detected  output  1  registered one-cycle pulse per match
match_count  output  CNT_W  number of matches since last reset or cfg_load; saturating
armed  output  1  1 while in RUN state
cfg_err  output  1  sticky flag; set by a load with illegal cfg_len, cleared by a legal load

Behaviour:
- Reset (rst=0, async, dominates): state=IDLE; pattern, len, overlap, history, fill, match_count all 0; detected=0, armed=0, cfg_err=0.
- State IDLE: a/a_valid are ignored; detected stays 0.
- IDLE + cfg_load with legal len -> RUN.
- Any state + cfg_load with len=0 or len>MAX_LEN: cfg_err<=1, state<=IDLE, stored config unchanged.
- RUN + legal cfg_load: reload config, clear history, fill and match_count, cfg_err<=0, stay in RUN.
- cfg_load takes priority over an a_valid in the same cycle; that bit is dropped.
- History: MAX_LEN-bit shift register, newest bit at [0]. On an accepted bit: hist <= {hist[MAX_LEN-2:0], a}; fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated combinationally on an accepted bit:
  - (fill+1) >= len, and
  - the low len bits of {hist, a} equal pattern[len-1:0].
- On a match: detected=1 in the next cycle for exactly one cycle; match_count increments, saturating at 2^CNT_W-1.
- Overlap=0: a match also clears fill to 0 (history contents need not be cleared, since fill gates the compare).
- Overlap=1: history and fill continue unchanged.
- a_valid=0: history, fill and counter hold; detected=0 that following cycle.
- Latency: the accepted bit that completes the pattern at edge N gives detected=1 during cycle N+1. Same timing as the Moore-style fixed detectors.
- Back-to-back matches (overlap=1, period-1 pattern such as all-ones) give detected=1 on consecutive cycles.
- len=1 is legal: every accepted bit equal to pattern[0] matches.
- FSM encoding is a 2-state enum (IDLE, RUN). Matching is done by the datapath, not by per-bit states.

Decomposition:
- Package seq_det_pkg holds: state enum (IDLE, RUN) and a function len_is_legal(len, MAX_LEN).
- Optional sub-module seq_det_sat_counter (width-parametrised saturating counter with clear and increment). Everything else stays in one module.

Test Plan:
- Overlap: load 1010, len 4, overlap 1; send 1,0,1,0,1,0 on consecutive cycles -> detected high the cycle after bit 4 and after bit 6; match_count=2.
- Non-overlap: same pattern, overlap 0; send 1,0,1,0,1,0,1,0 -> detected after bits 4 and 8 only; match_count=2. Bits 1..6 alone -> count=1.
- Legacy equivalence: load 110011, len 6, overlap 1; send 1,1,0,0,1,1,0,0,1,1 with a_valid gaps inserted between bits 3 and 4 -> detected after bits 6 and 10 only; gaps give no pulses; count=2.
- Config errors: cfg_load with len 0 -> cfg_err=1, armed=0, input ignored. Then a legal load -> cfg_err=0, armed=1, count=0.
- Saturation: CNT_W=2, pattern 1, len 1; send 5 ones -> 5 detected pulses; match_count stops at 3.
- Reset: drop rst mid-pattern (after 1,1,0 of 110011) asynchronously between edges -> outputs 0 immediately. After release, block is in IDLE and ignores input until cfg_load.
